// File: rtl/seq_array_div.sv
// seq_array_div
//   Sequential restoring divider, one quotient bit per clock. An accepted
//   start latches the operands; WIDTH restoring steps then produce the
//   quotient and remainder, which are published on entry to DONE. The done
//   pulse follows one edge later. A zero divisor skips the steps and reports
//   all-ones quotient, zero remainder and div_by_zero.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       division request, honoured only in IDLE
//   dividend    unsigned dividend (WIDTH), sampled on the accepting edge
//   divisor     unsigned divisor (DIV_WIDTH), sampled on the accepting edge
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle completion pulse
//   quotient    unsigned quotient (WIDTH), held until next completion
//   remainder   unsigned remainder (DIV_WIDTH), held until next completion
//   div_by_zero set when the last completed operation had a zero divisor
module seq_array_div #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     quotient,
   output logic [DIV_WIDTH-1:0] remainder,
   output logic                 div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]     dvd_sh;   // dividend shifts out MSB-first, quotient bits shift in
   logic [DIV_WIDTH-1:0] dvs;
   logic [DIV_WIDTH:0]   prem;     // partial remainder
   logic [CNT_W-1:0]     cnt;

   logic                 accept;
   logic                 last_step;

   logic [DIV_WIDTH:0]   shifted;
   logic [DIV_WIDTH+1:0] trial;
   logic                 q_bit;
   logic [DIV_WIDTH:0]   prem_next;
   logic [WIDTH-1:0]     dvd_next;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state and control decode
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      accept     = 1'b0;
      last_step  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // one restoring step: the extra top bit of trial is the borrow
   always_comb begin
      shifted   = {prem[DIV_WIDTH-1:0], dvd_sh[WIDTH-1]};
      trial     = {1'b0, shifted} - {2'b00, dvs};
      q_bit     = ~trial[DIV_WIDTH+1];
      prem_next = q_bit ? trial[DIV_WIDTH:0] : shifted;
      dvd_next  = {dvd_sh[WIDTH-2:0], q_bit};
   end

   // datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_sh      <= '0;
         dvs         <= '0;
         prem        <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         // done trails DONE by one edge, so it lands after the results settle
         done <= (state == DONE);
         if (accept) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            prem   <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            if (divisor == '0) begin
               quotient    <= '1;
               remainder   <= '0;
               div_by_zero <= 1'b1;
            end
         end else if (state == RUN) begin
            dvd_sh <= dvd_next;
            prem   <= prem_next;
            cnt    <= cnt - CNT_W'(1);
            if (last_step) begin
               quotient    <= dvd_next;
               remainder   <= prem_next[DIV_WIDTH-1:0];
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_array_div.sv
// tb_seq_array_div
//   Directed bench for seq_array_div (WIDTH=8, DIV_WIDTH=4): reset state,
//   latency, result holding, divide-by-zero, ignored start, mid-run reset and
//   a full sweep over every dividend with every nonzero divisor.
module tb_seq_array_div;

   localparam int unsigned W  = 8;
   localparam int unsigned DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  dividend;
   logic [DW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [DW-1:0] remainder;
   logic          div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_array_div #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Drive start for exactly one edge (E0); returns 1ns after E0.
   task automatic issue(input logic [W-1:0] a, input logic [DW-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Observe n falling edges after E0; k=0 is the cycle following E0.
   task automatic watch(input int n, output int pulses, output int first_k,
                        output logic [W-1:0] q, output logic [DW-1:0] r,
                        output logic z);
      pulses  = 0;
      first_k = -1;
      q = '0; r = '0; z = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (first_k < 0) begin
               first_k = k;
               q = quotient; r = remainder; z = div_by_zero;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (quotient !== 8'd0)  begin bad++; $display("FAIL reset_quot got=%0d want=0", quotient); end
      total++; if (remainder !== 4'd0) begin bad++; $display("FAIL reset_rem got=%0d want=0", remainder); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int p, fk; logic [W-1:0] q; logic [DW-1:0] r; logic z;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
      issue(8'd200, 4'd7);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b want=1", busy); end
      watch(15, p, fk, q, r, z);
      total++; if (p !== 1)  begin bad++; $display("FAIL basic_pulses got=%0d want=1", p); end
      total++; if (fk !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", fk); end
      total++; if (q !== 8'd28) begin bad++; $display("FAIL basic_quot got=%0d want=28", q); end
      total++; if (r !== 4'd4)  begin bad++; $display("FAIL basic_rem got=%0d want=4", r); end
      total++; if (z !== 1'b0)  begin bad++; $display("FAIL basic_dbz got=%b want=0", z); end
   endtask

   task automatic test_hold();
      int p, fk; logic [W-1:0] q; logic [DW-1:0] r; logic z;
      bit hold_bad;
      issue(8'd255, 4'd15);
      watch(12, p, fk, q, r, z);
      total++; if (fk !== 9 || p !== 1) begin bad++; $display("FAIL hold_first_done got=k%0d/p%0d want=k9/p1", fk, p); end
      total++; if (q !== 8'd17) begin bad++; $display("FAIL hold_first_quot got=%0d want=17", q); end
      total++; if (r !== 4'd0)  begin bad++; $display("FAIL hold_first_rem got=%0d want=0", r); end
      issue(8'd0, 4'd3);
      hold_bad = 1'b0;
      p = 0; fk = -1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k <= 7 && (quotient !== 8'd17 || remainder !== 4'd0)) hold_bad = 1'b1;
         if (done === 1'b1) begin
            p++;
            if (fk < 0) begin fk = k; q = quotient; r = remainder; end
         end
      end
      total++; if (hold_bad) begin bad++; $display("FAIL hold_stable got=changed want=17/0 until done"); end
      total++; if (fk !== 9 || p !== 1) begin bad++; $display("FAIL hold_second_done got=k%0d/p%0d want=k9/p1", fk, p); end
      total++; if (q !== 8'd0) begin bad++; $display("FAIL hold_second_quot got=%0d want=0", q); end
      total++; if (r !== 4'd0) begin bad++; $display("FAIL hold_second_rem got=%0d want=0", r); end
   endtask

   task automatic test_div_zero();
      int p, fk; logic [W-1:0] q; logic [DW-1:0] r; logic z;
      issue(8'd5, 4'd0);
      watch(6, p, fk, q, r, z);
      total++; if (p !== 1)  begin bad++; $display("FAIL dz_pulses got=%0d want=1", p); end
      total++; if (fk !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", fk); end
      total++; if (q !== 8'd255) begin bad++; $display("FAIL dz_quot got=%0d want=255", q); end
      total++; if (r !== 4'd0)   begin bad++; $display("FAIL dz_rem got=%0d want=0", r); end
      total++; if (z !== 1'b1)   begin bad++; $display("FAIL dz_flag got=%b want=1", z); end
      total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag_hold got=%b want=1", div_by_zero); end
      issue(8'd9, 4'd2);
      watch(12, p, fk, q, r, z);
      total++; if (fk !== 9) begin bad++; $display("FAIL dz_next_latency got=%0d want=9", fk); end
      total++; if (q !== 8'd4) begin bad++; $display("FAIL dz_next_quot got=%0d want=4", q); end
      total++; if (r !== 4'd1) begin bad++; $display("FAIL dz_next_rem got=%0d want=1", r); end
      total++; if (z !== 1'b0) begin bad++; $display("FAIL dz_next_flag got=%b want=0", z); end
   endtask

   task automatic test_start_ignored();
      int p, fk; logic [W-1:0] q; logic [DW-1:0] r;
      bit busy_bad;
      issue(8'd100, 4'd9);
      p = 0; fk = -1; busy_bad = 1'b0; q = '0; r = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k <= 9 && busy !== (k <= 8)) busy_bad = 1'b1;
         if (done === 1'b1) begin
            p++;
            if (fk < 0) begin fk = k; q = quotient; r = remainder; end
         end
         // second request straddles edge E0+3 with different operands
         if (k == 2) begin dividend = 8'd50; divisor = 4'd5; start = 1'b1; end
         if (k == 3) start = 1'b0;
      end
      total++; if (p !== 1)  begin bad++; $display("FAIL ign_pulses got=%0d want=1", p); end
      total++; if (fk !== 9) begin bad++; $display("FAIL ign_latency got=%0d want=9", fk); end
      total++; if (q !== 8'd11) begin bad++; $display("FAIL ign_quot got=%0d want=11", q); end
      total++; if (r !== 4'd1)  begin bad++; $display("FAIL ign_rem got=%0d want=1", r); end
      total++; if (busy_bad) begin bad++; $display("FAIL ign_busy got=wrong want=high k0..8 low k9"); end
   endtask

   task automatic test_reset_mid();
      int p, fk; logic [W-1:0] q; logic [DW-1:0] r; logic z;
      issue(8'd200, 4'd7);
      for (int k = 0; k < 4; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done); end
      total++; if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
         bad++; $display("FAIL rmid_outputs got=%0d/%0d/%b want=0/0/0", quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      watch(20, p, fk, q, r, z);
      total++; if (p !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", p); end
      issue(8'd13, 4'd4);
      watch(12, p, fk, q, r, z);
      total++; if (fk !== 9) begin bad++; $display("FAIL rmid_next_latency got=%0d want=9", fk); end
      total++; if (q !== 8'd3) begin bad++; $display("FAIL rmid_next_quot got=%0d want=3", q); end
      total++; if (r !== 4'd1) begin bad++; $display("FAIL rmid_next_rem got=%0d want=1", r); end
   endtask

   task automatic test_back_to_back();
      int got;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            issue(W'(a), DW'(b));
            got = 0;
            for (int k = 0; k < 20 && got == 0; k++) begin
               @(negedge clk);
               if (done === 1'b1) got = 1;
            end
            total++;
            if (got == 0) begin
               bad++; $display("FAIL sweep_timeout %0d/%0d got=no done want=done", a, b);
            end else if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b
                         || div_by_zero !== 1'b0) begin
               bad++;
               $display("FAIL sweep %0d/%0d got=q%0d r%0d z%b want=q%0d r%0d z0",
                        a, b, quotient, remainder, div_by_zero, a / b, a % b);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      test_reset();
      test_basic();
      test_hold();
      test_div_zero();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
